// File: rtl/l2_bank_pkg.sv
// Shared types and constants for the L2 bank slave.
package l2_bank_pkg;

    typedef enum logic [1:0] {
        INIT  = 2'd0,
        SERVE = 2'd1,
        DRAIN = 2'd2
    } state_e;

    localparam logic OPC_OK  = 1'b0;
    localparam logic OPC_ERR = 1'b1;

    localparam int unsigned LATENCY_MAX = 4;

endpackage

// File: rtl/l2_bank_rsp_fifo.sv
// First-word-fall-through response FIFO; a push into an empty FIFO is visible
// on the output in the same cycle and is not stored if popped right away.
module l2_bank_rsp_fifo #(
    parameter int unsigned DEPTH = 2,
    parameter int unsigned WIDTH = 33
) (
    input  logic             clk_i,
    input  logic             rst_i,
    input  logic             push_i,
    input  logic [WIDTH-1:0] data_i,
    input  logic             pop_i,
    output logic             valid_o,
    output logic [WIDTH-1:0] data_o
);

    localparam int unsigned PW = (DEPTH > 1) ? $clog2(DEPTH) : 1;
    localparam int unsigned CW = $clog2(DEPTH + 1);

    logic [WIDTH-1:0] mem_q [DEPTH];
    logic [WIDTH-1:0] mem_d [DEPTH];
    logic [PW-1:0]    rd_q, rd_d, wr_q, wr_d;
    logic [CW-1:0]    cnt_q, cnt_d;
    logic             empty, pop, store, take;

    function automatic logic [PW-1:0] ptr_inc(input logic [PW-1:0] p);
        return (p == PW'(DEPTH - 1)) ? '0 : p + 1'b1;
    endfunction

    always_comb begin
        empty   = (cnt_q == '0);
        valid_o = !empty || push_i;
        data_o  = empty ? data_i : mem_q[rd_q];
        pop     = pop_i && valid_o;
        store   = push_i && !(empty && pop);
        take    = pop && !empty;

        mem_d = mem_q;
        if (store) begin
            mem_d[wr_q] = data_i;
        end
        wr_d  = store ? ptr_inc(wr_q) : wr_q;
        rd_d  = take ? ptr_inc(rd_q) : rd_q;
        cnt_d = cnt_q + CW'(store) - CW'(take);
    end

    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            rd_q  <= '0;
            wr_q  <= '0;
            cnt_q <= '0;
        end else begin
            rd_q  <= rd_d;
            wr_q  <= wr_d;
            cnt_q <= cnt_d;
        end
    end

    always_ff @(posedge clk_i) begin
        mem_q <= mem_d;
    end

endmodule

// File: rtl/tc_sram.sv
// Behavioural single/multi-port SRAM with byte enables and a fixed read latency.
module tc_sram #(
    parameter int unsigned NumWords  = 1024,
    parameter int unsigned DataWidth = 32,
    parameter int unsigned ByteWidth = 8,
    parameter int unsigned NumPorts  = 1,
    parameter int unsigned Latency   = 1,
    parameter int unsigned AddrWidth = (NumWords > 1) ? $clog2(NumWords) : 1,
    parameter int unsigned BeWidth   = (DataWidth + ByteWidth - 1) / ByteWidth
) (
    input  logic                                clk_i,
    input  logic                                rst_ni,
    input  logic [NumPorts-1:0]                 req_i,
    input  logic [NumPorts-1:0]                 we_i,
    input  logic [NumPorts-1:0][AddrWidth-1:0]  addr_i,
    input  logic [NumPorts-1:0][DataWidth-1:0]  wdata_i,
    input  logic [NumPorts-1:0][BeWidth-1:0]    be_i,
    output logic [NumPorts-1:0][DataWidth-1:0]  rdata_o
);

    logic [DataWidth-1:0] mem_q   [NumWords];
    logic [DataWidth-1:0] rpipe_q [NumPorts][Latency];
    logic [DataWidth-1:0] rpipe_d [NumPorts][Latency];

    always_ff @(posedge clk_i) begin
        for (int unsigned p = 0; p < NumPorts; p++) begin
            for (int unsigned b = 0; b < BeWidth; b++) begin
                if (req_i[p] && we_i[p] && be_i[p][b]) begin
                    mem_q[addr_i[p]][b*ByteWidth +: ByteWidth] <= wdata_i[p][b*ByteWidth +: ByteWidth];
                end
            end
        end
    end

    always_comb begin
        rpipe_d = rpipe_q;
        for (int unsigned p = 0; p < NumPorts; p++) begin
            if (req_i[p] && !we_i[p]) begin
                rpipe_d[p][0] = mem_q[addr_i[p]];
            end
            for (int unsigned s = 1; s < Latency; s++) begin
                rpipe_d[p][s] = rpipe_q[p][s-1];
            end
        end
    end

    always_ff @(posedge clk_i) begin
        if (!rst_ni) begin
            for (int unsigned p = 0; p < NumPorts; p++) begin
                for (int unsigned s = 0; s < Latency; s++) begin
                    rpipe_q[p][s] <= '0;
                end
            end
        end else begin
            rpipe_q <= rpipe_d;
        end
    end

    always_comb begin
        for (int unsigned p = 0; p < NumPorts; p++) begin
            rdata_o[p] = rpipe_q[p][Latency-1];
        end
    end

endmodule

// File: rtl/l2_bank_pipe.sv
// Single L2 bank slave: range-checked SRAM access, latency-matched response
// pipeline, credit-gated grant and a hardware zero-initialisation sweep.
module l2_bank_pipe
    import l2_bank_pkg::*;
#(
    parameter int unsigned            NUM_WORDS  = 8192,
    parameter int unsigned            DATA_WIDTH = 32,
    parameter int unsigned            ADDR_WIDTH = 32,
    parameter logic [ADDR_WIDTH-1:0]  BASE_ADDR  = 32'h1C01_0000,
    parameter int unsigned            LATENCY    = 1,
    parameter int unsigned            RSP_DEPTH  = LATENCY + 1,
    parameter bit                     ZERO_INIT  = 1'b1
) (
    input  logic                      clk_i,
    input  logic                      rst_i,
    input  logic                      init_req_i,
    output logic                      init_done_o,
    input  logic                      req_i,
    output logic                      gnt_o,
    input  logic [ADDR_WIDTH-1:0]     add_i,
    input  logic                      wen_i,
    input  logic [DATA_WIDTH-1:0]     wdata_i,
    input  logic [DATA_WIDTH/8-1:0]   be_i,
    output logic                      r_valid_o,
    input  logic                      r_ready_i,
    output logic [DATA_WIDTH-1:0]     r_rdata_o,
    output logic                      r_opc_o
);

    localparam int unsigned BE_W    = DATA_WIDTH / 8;
    localparam int unsigned OFF_B   = $clog2(BE_W);
    localparam int unsigned WORD_AW = $clog2(NUM_WORDS);
    localparam int unsigned OUT_W   = $clog2(RSP_DEPTH + 1);
    localparam int unsigned LAT     = (LATENCY < 1) ? 1 :
                                      (LATENCY > LATENCY_MAX) ? LATENCY_MAX : LATENCY;
    localparam logic [ADDR_WIDTH:0] BANK_BYTES = (ADDR_WIDTH+1)'(NUM_WORDS * BE_W);
    localparam state_e RST_STATE = ZERO_INIT ? INIT : SERVE;

    typedef struct packed {
        logic                  opc;
        logic [DATA_WIDTH-1:0] rdata;
    } rsp_t;

    state_e               state_q, state_d;
    logic [WORD_AW-1:0]   cnt_q, cnt_d;
    logic [OUT_W-1:0]     out_q, out_d;
    logic [LAT-1:0]       vld_q, vld_d, err_q, err_d, rd_q, rd_d;

    logic [ADDR_WIDTH-1:0] off;
    logic                  addr_err;
    logic [WORD_AW-1:0]    word_idx;
    logic                  unused_off;

    logic                  sram_req, sram_we, sram_rst_n;
    logic [WORD_AW-1:0]    sram_addr;
    logic [DATA_WIDTH-1:0] sram_wdata, sram_rdata;
    logic [BE_W-1:0]       sram_be;

    rsp_t                  push_rsp, head_rsp;
    logic                  rsp_pop;

    // Addresses below the base wrap to huge offsets and fall out of range too.
    assign off        = add_i - BASE_ADDR;
    assign addr_err   = {1'b0, off} >= BANK_BYTES;
    assign word_idx   = off[OFF_B +: WORD_AW];
    assign unused_off = ^off;

    always_comb begin
        state_d    = state_q;
        cnt_d      = cnt_q;
        gnt_o      = 1'b0;
        sram_req   = 1'b0;
        sram_we    = 1'b0;
        sram_addr  = word_idx;
        sram_wdata = wdata_i;
        sram_be    = be_i;
        unique case (state_q)
            INIT: begin
                sram_req   = 1'b1;
                sram_we    = 1'b1;
                sram_addr  = cnt_q;
                sram_wdata = '0;
                sram_be    = '1;
                if (cnt_q == WORD_AW'(NUM_WORDS - 1)) begin
                    state_d = SERVE;
                    cnt_d   = '0;
                end else begin
                    cnt_d = cnt_q + 1'b1;
                end
            end
            SERVE: begin
                if (init_req_i) begin
                    state_d = DRAIN;
                end else begin
                    gnt_o = req_i && (out_q < OUT_W'(RSP_DEPTH));
                    if (gnt_o && !addr_err) begin
                        sram_req = 1'b1;
                        sram_we  = !wen_i;
                    end
                end
            end
            DRAIN: begin
                if (out_q == '0) begin
                    state_d = INIT;
                    cnt_d   = '0;
                end
            end
            default: state_d = RST_STATE;
        endcase
    end

    assign init_done_o = (state_q == SERVE);

    // The valid/err/read shift register lines up with the SRAM read latency.
    always_comb begin
        vld_d    = vld_q;
        err_d    = err_q;
        rd_d     = rd_q;
        vld_d[0] = gnt_o;
        err_d[0] = addr_err;
        rd_d[0]  = wen_i;
        for (int unsigned i = 1; i < LAT; i++) begin
            vld_d[i] = vld_q[i-1];
            err_d[i] = err_q[i-1];
            rd_d[i]  = rd_q[i-1];
        end
        push_rsp.opc   = err_q[LAT-1] ? OPC_ERR : OPC_OK;
        push_rsp.rdata = (vld_q[LAT-1] && rd_q[LAT-1] && !err_q[LAT-1]) ? sram_rdata : '0;
    end

    assign rsp_pop = r_valid_o && r_ready_i;
    assign out_d   = out_q + OUT_W'(gnt_o) - OUT_W'(rsp_pop);

    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            state_q <= RST_STATE;
            cnt_q   <= '0;
            out_q   <= '0;
            vld_q   <= '0;
            err_q   <= '0;
            rd_q    <= '0;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
            out_q   <= out_d;
            vld_q   <= vld_d;
            err_q   <= err_d;
            rd_q    <= rd_d;
        end
    end

    assign sram_rst_n = ~rst_i;

    tc_sram #(
        .NumWords  (NUM_WORDS),
        .DataWidth (DATA_WIDTH),
        .ByteWidth (8),
        .NumPorts  (1),
        .Latency   (LAT)
    ) u_sram (
        .clk_i   (clk_i),
        .rst_ni  (sram_rst_n),
        .req_i   (sram_req),
        .we_i    (sram_we),
        .addr_i  (sram_addr),
        .wdata_i (sram_wdata),
        .be_i    (sram_be),
        .rdata_o (sram_rdata)
    );

    l2_bank_rsp_fifo #(
        .DEPTH (RSP_DEPTH),
        .WIDTH ($bits(rsp_t))
    ) u_rsp_fifo (
        .clk_i   (clk_i),
        .rst_i   (rst_i),
        .push_i  (vld_q[LAT-1]),
        .data_i  (push_rsp),
        .pop_i   (r_ready_i),
        .valid_o (r_valid_o),
        .data_o  (head_rsp)
    );

    assign r_rdata_o = head_rsp.rdata;
    assign r_opc_o   = head_rsp.opc;

endmodule

// File: tb/tb_l2_bank_pipe.sv
// Directed and randomized bench for l2_bank_pipe against a transaction-level model.
module tb_l2_bank_pipe;

    localparam int unsigned NW    = 64;
    localparam int unsigned LAT   = 2;
    localparam int unsigned DEPTH = LAT + 1;
    localparam logic [31:0] BASE  = 32'h1C01_0000;

    logic        clk, rst_i, init_req_i, init_done_o, req_i, gnt_o, wen_i;
    logic [31:0] add_i, wdata_i, r_rdata_o;
    logic [3:0]  be_i;
    logic        r_valid_o, r_ready_i, r_opc_o;

    l2_bank_pipe #(
        .NUM_WORDS  (NW),
        .DATA_WIDTH (32),
        .ADDR_WIDTH (32),
        .BASE_ADDR  (BASE),
        .LATENCY    (LAT),
        .RSP_DEPTH  (DEPTH),
        .ZERO_INIT  (1'b1)
    ) dut (
        .clk_i       (clk),
        .rst_i       (rst_i),
        .init_req_i  (init_req_i),
        .init_done_o (init_done_o),
        .req_i       (req_i),
        .gnt_o       (gnt_o),
        .add_i       (add_i),
        .wen_i       (wen_i),
        .wdata_i     (wdata_i),
        .be_i        (be_i),
        .r_valid_o   (r_valid_o),
        .r_ready_i   (r_ready_i),
        .r_rdata_o   (r_rdata_o),
        .r_opc_o     (r_opc_o)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    int cyc = 0;
    always @(posedge clk) cyc++;

    int checks = 0;
    int passed = 0;
    int fails  = 0;

    typedef struct {
        logic        opc;
        logic [31:0] data;
        int          gcyc;
        bit          lat_chk;
    } exp_t;

    exp_t        expq[$];
    logic [31:0] ref_mem [NW];
    bit          steady     = 1'b0;
    bit          rand_ready = 1'b0;
    int          head_first = -1;

    task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        checks++;
        assert (obs === exp) passed++;
        else begin
            fails++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    function automatic void clear_model();
        foreach (ref_mem[i]) ref_mem[i] = '0;
    endfunction

    // Transaction-level model: decides the response when the grant is seen.
    function automatic void accept(input logic [31:0] a, input logic rd,
                                   input logic [31:0] wd, input logic [3:0] be);
        logic [31:0] off;
        int          idx;
        exp_t        e;
        off       = a - BASE;
        e.gcyc    = cyc;
        e.lat_chk = (expq.size() == 0) || (steady && r_ready_i);
        e.data    = '0;
        if (off >= NW * 4) begin
            e.opc = 1'b1;
        end else begin
            e.opc = 1'b0;
            idx   = int'(off / 4);
            if (rd) begin
                e.data = ref_mem[idx];
            end else begin
                for (int b = 0; b < 4; b++)
                    if (be[b]) ref_mem[idx][8*b +: 8] = wd[8*b +: 8];
            end
        end
        expq.push_back(e);
    endfunction

    always @(negedge clk) begin
        exp_t e;
        if (!r_ready_i) steady = 1'b0;
        else if (expq.size() == 0) steady = 1'b1;
        if (r_valid_o) begin
            if (expq.size() == 0) begin
                check("spurious_valid", 64'(r_valid_o), 64'(0));
            end else begin
                if (head_first < 0) head_first = cyc;
                if (r_ready_i) begin
                    e = expq.pop_front();
                    check("rsp_opc", 64'(r_opc_o), 64'(e.opc));
                    check("rsp_rdata", 64'(r_rdata_o), 64'(e.data));
                    if (e.lat_chk) check("rsp_latency", 64'(head_first - e.gcyc), 64'(LAT));
                    head_first = -1;
                end
            end
        end
    end

    // Called at posedge+1; returns at posedge+1 after the grant edge.
    task automatic issue(input logic [31:0] a, input logic rd, input logic [31:0] wd,
                         input logic [3:0] be, input bit chk_noreq, output int waited);
        bit done = 1'b0;
        waited = 0;
        req_i = 1'b1; add_i = a; wen_i = rd; wdata_i = wd; be_i = be;
        for (int n = 0; n < 200 && !done; n++) begin
            if (rand_ready) r_ready_i = 1'($urandom_range(0, 1));
            @(negedge clk);
            if (gnt_o) begin
                accept(a, rd, wd, be);
                done = 1'b1;
                if (chk_noreq) check("err_sram_req", 64'(dut.sram_req), 64'(0));
            end else begin
                waited++;
            end
            @(posedge clk); #1;
        end
        req_i = 1'b0;
        check("granted", 64'(done), 64'(1));
    endtask

    task automatic drain();
        for (int n = 0; n < 300 && expq.size() != 0; n++) begin
            @(posedge clk); #1;
        end
        check("drain_empty", 64'(expq.size()), 64'(0));
    endtask

    task automatic wait_done(output int n);
        n = 0;
        while (!init_done_o && n < 1000) begin
            @(posedge clk); #1;
            n++;
        end
        check("init_done", 64'(init_done_o), 64'(1));
        clear_model();
    endtask

    initial begin
        #500000;
        $display("FAIL watchdog expired at cycle %0d", cyc);
        $fatal(1);
    end

    initial begin
        int w, n, gcount;
        rst_i = 1'b1; init_req_i = 1'b0; req_i = 1'b1; r_ready_i = 1'b1;
        add_i = BASE; wen_i = 1'b1; wdata_i = '0; be_i = '0;
        clear_model();
        repeat (3) @(posedge clk);
        #1;
        check("rst_gnt", 64'(gnt_o), 64'(0));
        check("rst_r_valid", 64'(r_valid_o), 64'(0));
        check("rst_r_rdata", 64'(r_rdata_o), 64'(0));
        check("rst_r_opc", 64'(r_opc_o), 64'(0));
        check("rst_init_done", 64'(init_done_o), 64'(0));
        req_i = 1'b0;
        rst_i = 1'b0;
        wait_done(n);
        check("sweep_cycles", 64'(n), 64'(NW));

        // Swept memory reads zero; then write/read back-to-back
        issue(BASE + 20, 1'b1, '0, '0, 1'b0, w);
        issue(BASE, 1'b0, 32'h1234_5678, 4'hF, 1'b0, w);
        check("b2b_wr_wait", 64'(w), 64'(0));
        issue(BASE, 1'b1, '0, '0, 1'b0, w);
        check("b2b_rd_wait", 64'(w), 64'(0));
        drain();

        // Byte enables
        issue(BASE + 8, 1'b0, 32'hFFFF_FFFF, 4'hF, 1'b0, w);
        issue(BASE + 8, 1'b0, 32'h0000_00AA, 4'b0001, 1'b0, w);
        issue(BASE + 8, 1'b1, '0, '0, 1'b0, w);
        for (int k = 1; k <= 4; k++) issue(BASE + 32'(4*k) + 32'h40, 1'b0, 32'hA000_0000 + 32'(k), 4'hF, 1'b0, w);
        drain();

        // Back-pressure: only DEPTH grants while r_ready_i is low
        r_ready_i = 1'b0;
        gcount = 0;
        req_i = 1'b1; wen_i = 1'b1;
        for (int c = 0; c < 8 && gcount < 4; c++) begin
            add_i = BASE + 32'(4*(gcount+1)) + 32'h40;
            @(negedge clk);
            if (gnt_o) begin accept(add_i, 1'b1, '0, '0); gcount++; end
            @(posedge clk); #1;
        end
        check("bp_grants", 64'(gcount), 64'(DEPTH));
        check("bp_gnt_low", 64'(gnt_o), 64'(0));
        r_ready_i = 1'b1;
        for (int c = 0; c < 50 && gcount < 4; c++) begin
            add_i = BASE + 32'(4*(gcount+1)) + 32'h40;
            @(negedge clk);
            if (gnt_o) begin accept(add_i, 1'b1, '0, '0); gcount++; end
            @(posedge clk); #1;
        end
        req_i = 1'b0;
        check("bp_total", 64'(gcount), 64'(4));
        drain();

        // Out-of-range accesses
        issue(BASE + NW*4, 1'b1, '0, '0, 1'b1, w);
        issue(BASE - 4, 1'b1, '0, '0, 1'b1, w);
        issue(BASE + 32'h1000, 1'b0, 32'h5555_5555, 4'hF, 1'b1, w);
        drain();

        // init_req with two reads outstanding
        issue(BASE + 20, 1'b0, 32'hDEAD_BEEF, 4'hF, 1'b0, w);
        issue(BASE + 20, 1'b1, '0, '0, 1'b0, w);
        drain();
        r_ready_i = 1'b0;
        issue(BASE + 20, 1'b1, '0, '0, 1'b0, w);
        issue(BASE, 1'b1, '0, '0, 1'b0, w);
        init_req_i = 1'b1; req_i = 1'b1; add_i = BASE; wen_i = 1'b1;
        @(negedge clk);
        check("init_req_gnt", 64'(gnt_o), 64'(0));
        @(posedge clk); #1;
        init_req_i = 1'b0;
        check("drain_not_done", 64'(init_done_o), 64'(0));
        @(negedge clk);
        check("drain_gnt", 64'(gnt_o), 64'(0));
        @(posedge clk); #1;
        req_i = 1'b0;
        r_ready_i = 1'b1;
        wait_done(n);
        check("drain_delivered", 64'(expq.size()), 64'(0));
        issue(BASE + 20, 1'b1, '0, '0, 1'b0, w);
        issue(BASE, 1'b1, '0, '0, 1'b0, w);
        issue(BASE + 8, 1'b1, '0, '0, 1'b0, w);
        drain();

        // Randomized traffic with random back-pressure
        rand_ready = 1'b1;
        for (int t = 0; t < 150; t++) begin
            logic [31:0] a;
            if ($urandom_range(0, 9) == 0) a = $urandom;
            else a = BASE + 32'($urandom_range(0, NW-1) * 4) + 32'($urandom_range(0, 3));
            issue(a, 1'($urandom_range(0, 1)), $urandom, 4'($urandom_range(0, 15)), 1'b0, w);
        end
        rand_ready = 1'b0;
        r_ready_i = 1'b1;
        drain();

        // Reset with two responses outstanding
        r_ready_i = 1'b0;
        issue(BASE + 4, 1'b1, '0, '0, 1'b0, w);
        issue(BASE + 8, 1'b1, '0, '0, 1'b0, w);
        rst_i = 1'b1;
        @(posedge clk); #1;
        expq.delete();
        head_first = -1;
        r_ready_i = 1'b1;
        check("rst_mid_valid", 64'(r_valid_o), 64'(0));
        rst_i = 1'b0;
        wait_done(n);
        check("resweep_cycles", 64'(n), 64'(NW));
        for (int k = 0; k < 4; k++) begin
            @(negedge clk);
            check("post_rst_valid", 64'(r_valid_o), 64'(0));
            @(posedge clk); #1;
        end
        issue(BASE + 4, 1'b1, '0, '0, 1'b0, w);
        drain();

        $display("%0d/%0d checks passed", passed, checks);
        $finish;
    end

endmodule

// File: doc/l2_bank_pipe.md
Name: l2_bank_pipe

Overview:
- Parametrised single-bank L2 memory slave. It is the successor to the fixed 1-cycle interleaved/private bank wrappers.
- Adds four things those wrappers lack: configurable data width, depth and SRAM read latency; a response FIFO with r_ready back-pressure and credit-gated grant; out-of-range error responses; a hardware zero-initialisation sweep.
- One instance per bank in the SoC L2 subsystem, behind the TCDM crossbar.

Parameters:
- NUM_WORDS, 8192, bank depth in DATA_WIDTH words; power of two, >= 2.
- DATA_WIDTH, 32, word width; multiple of 8.
- ADDR_WIDTH, 32, byte-address width.
- BASE_ADDR, 32'h1C01_0000, byte address of word 0.
- LATENCY, 1, SRAM read latency in cycles; legal range 1..4.
- RSP_DEPTH, LATENCY+1, maximum outstanding transactions (in flight plus queued).
- ZERO_INIT, 1, 1 = bank is zero-swept automatically after reset.

Ports:
- clk_i  in  1  clock.
- rst_i  in  1  reset.
- init_req_i  in  1  pulse; requests a zero sweep.
- init_done_o  out  1  1 = bank usable.
- req_i  in  1  request valid.
- gnt_o  out  1  request accepted this cycle.
- add_i  in  ADDR_WIDTH  byte address.
- wen_i  in  1  1 = read, 0 = write.
- wdata_i  in  DATA_WIDTH  write data.
- be_i  in  DATA_WIDTH/8  byte enables.
- r_valid_o  out  1  response valid.
- r_ready_i  in  1  response consumed.
- r_rdata_o  out  DATA_WIDTH  read data.
- r_opc_o  out  1  0 = ok, 1 = address error.

Behaviour:
- Clocking and reset (already decided): one clock, clk_i; reset rst_i is synchronous and active-high.
- Reset values:
  - state = INIT if ZERO_INIT, else SERVE.
  - Sweep counter = 0; latency pipeline and FIFO cleared; outstanding = 0.
  - r_valid_o = 0, r_rdata_o = 0, r_opc_o = 0, init_done_o = !ZERO_INIT.
  - gnt_o = 0, since it is combinational and state/credit-gated.
- Reset mid-operation discards all in-flight and queued responses; none is emitted afterwards.
- FSM states: INIT, SERVE, DRAIN.
  - INIT: gnt_o = 0. Writes zero to word cnt with all byte enables set, one word per cycle, cnt 0..NUM_WORDS-1. After the last word, go to SERVE; init_done_o rises the following cycle. Sweep takes exactly NUM_WORDS cycles.
  - SERVE: gnt_o = req_i && (outstanding < RSP_DEPTH). If init_req_i is seen, go to DRAIN; gnt_o = 0 in that same cycle.
  - DRAIN: gnt_o = 0 and init_done_o = 0. When outstanding == 0, reset cnt and go to INIT.
  - init_req_i is ignored in INIT and DRAIN.
- Addressing: off = add_i - BASE_ADDR, using ADDR_WIDTH unsigned wrap. Word index = off >> log2(DATA_WIDTH/8); low byte bits are ignored.
  - If off >= NUM_WORDS*DATA_WIDTH/8 (this includes addresses below the base, via wrap), the transaction is an error: no SRAM access; the response has r_opc_o = 1 and r_rdata_o = 0.
- Writes: only enabled bytes are updated. Every write also produces exactly one response (r_opc per above, r_rdata_o = 0).
- Reads: return SRAM data. A read after a write to the same word, granted on the next cycle, returns the new data.
- Pipeline: each grant enters a LATENCY-stage valid/err shift register. At its exit, {opc, rdata} is pushed into a first-word-fall-through FIFO of RSP_DEPTH entries.
- Latency: with FIFO empty and r_ready_i high, r_valid_o asserts exactly LATENCY cycles after the gnt cycle.
- Response handshake: r_valid_o, r_rdata_o and r_opc_o stay stable until r_ready_i. Pop occurs on r_valid_o && r_ready_i. Responses are in grant order.
- Credit: outstanding increments on gnt and decrements on pop; both in one cycle leaves it unchanged.
  - Credit gating guarantees no FIFO overflow.
  - With r_ready_i held high, throughput is one grant per cycle.
  - With r_ready_i low, at most RSP_DEPTH grants are made, then gnt_o = 0 until a pop.

Decomposition:
- Package l2_bank_pkg:
  - state enum {INIT, SERVE, DRAIN};
  - OPC_OK = 1'b0, OPC_ERR = 1'b1;
  - LATENCY_MAX = 4.
- Sub-module l2_bank_rsp_fifo: parametrised FWFT FIFO (DEPTH, WIDTH), synchronous active-high reset.
- SRAM: tc_sram (NumPorts 1, Latency LATENCY).
- Response entry type is declared locally, because its width depends on DATA_WIDTH.

Test Plan:
- Sweep after reset: ZERO_INIT=1, NUM_WORDS=64, first preload word 5 = 32'hDEADBEEF through the backdoor. Expect init_done_o high after 64 cycles, then a read of BASE_ADDR+20 returns 0 with r_opc 0.
- Back-to-back throughput: LATENCY=2, r_ready_i=1. Write 32'h1234_5678 to BASE_ADDR, then read it on the next cycle. Expect gnt_o both cycles, r_valid_o 2 cycles after each grant, and read data 32'h1234_5678.
- Byte enables: write 32'hFFFF_FFFF, then write 32'h0000_00AA with be=4'b0001. Expect a read to return 32'hFFFF_FFAA.
- Back-pressure: LATENCY=1, RSP_DEPTH=2, r_ready_i=0, 4 reads. Expect exactly 2 grants then gnt_o=0. Raise r_ready_i: 4 responses come back in order, none lost or duplicated.
- Address error: read BASE_ADDR + NUM_WORDS*4, and read BASE_ADDR-4. Expect r_opc_o=1 and r_rdata_o=0 for both, with SRAM req never asserted.
- Mid-traffic events:
  - init_req_i pulsed with 2 reads outstanding: expect both responses delivered, then INIT sweep, then all words 0.
  - rst_i asserted with 2 outstanding: expect no r_valid_o after reset.
